// File: rtl/axi_config_regfile.sv
// axi_config_regfile
//   Control/status register bank behind the AXI config read/write adapters.
//   Reads are a zero-latency combinational mux on raddr; writes commit on
//   the rising clk edge where wr is high. Also holds sticky STATUS capture,
//   a registered interrupt and a saturating event counter.
//
//   Optional feature macro: AXI_CONFIG_REGFILE_TIMESTAMP_EN
//     defined   : offset 0x18 is a free-running, writable cycle counter
//     undefined : offset 0x18 reads 0, writes ignored, no counter flops
//
// Ports
//   clk        in   sole clock
//   rst_n      in   asynchronous active-low reset
//   rd         in   read strobe            raddr  in  read byte address
//   rdata      out  read data (comb.)      rvalid out equals rd (comb.)
//   wr         in   write strobe           waddr  in  write byte address
//   wdata      in   write data             wstrb  in  byte enables
//   status_in  in   per-bit set pulses into STATUS
//   event_in   in   EVCNT increment pulse
//   ctrl_out   out  CTRL register contents
//   user_out   out  USER registers, USER[0] in the LSBs
//   irq        out  registered |(STATUS & IRQ_EN)
module axi_config_regfile #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [31:0]           ID_VALUE   = 32'h4346_4701,
  parameter int                    N_USER     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rd,
  input  logic [ADDR_WIDTH-1:0]        raddr,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         rvalid,
  input  logic                         wr,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [STRB_WIDTH-1:0]        wstrb,
  input  logic [31:0]                  status_in,
  input  logic                         event_in,
  output logic [31:0]                  ctrl_out,
  output logic [32*N_USER-1:0]         user_out,
  output logic                         irq
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("axi_config_regfile: only DATA_WIDTH = 32 is supported");
  end
  if (N_USER < 1 || N_USER > 8) begin : g_bad_nuser
    $error("axi_config_regfile: N_USER must be in 1..8");
  end
  if (BASE_ADDR[7:0] != 8'h00) begin : g_bad_base
    $error("axi_config_regfile: BASE_ADDR[7:0] must be zero");
  end

  localparam logic [5:0] IDX_ID      = 6'd0;
  localparam logic [5:0] IDX_SCRATCH = 6'd1;
  localparam logic [5:0] IDX_CTRL    = 6'd2;
  localparam logic [5:0] IDX_STATUS  = 6'd3;
  localparam logic [5:0] IDX_IRQ_EN  = 6'd4;
  localparam logic [5:0] IDX_EVCNT   = 6'd5;
  localparam logic [5:0] IDX_TS      = 6'd6;
  localparam int         IDX_USER0   = 8;

  // Expand byte strobes into a bit mask.
  function automatic logic [DATA_WIDTH-1:0] strb_mask(input logic [STRB_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      m[8*i +: 8] = {8{s[i]}};
    end
    return m;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_v,
                                                  input logic [DATA_WIDTH-1:0] new_v,
                                                  input logic [DATA_WIDTH-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  logic [DATA_WIDTH-1:0] scratch_q, ctrl_q, status, irq_en_q, evcnt;
  logic [DATA_WIDTH-1:0] user_q [N_USER];
  logic [DATA_WIDTH-1:0] status_next, irq_en_next, wmask, ts_rd;

  logic       w_hit, r_hit, w_en;
  logic [5:0] w_idx, r_idx;
  logic       unused_addr_lsbs;

  assign w_hit = (waddr[ADDR_WIDTH-1:8] == BASE_ADDR[ADDR_WIDTH-1:8]);
  assign r_hit = (raddr[ADDR_WIDTH-1:8] == BASE_ADDR[ADDR_WIDTH-1:8]);
  assign w_idx = waddr[7:2];
  assign r_idx = raddr[7:2];
  assign unused_addr_lsbs = ^{waddr[1:0], raddr[1:0]};

  // An all-zero wstrb is a no-op everywhere, including the clear-on-write
  // side effects of STATUS and EVCNT.
  assign w_en  = wr && w_hit && (|wstrb);
  assign wmask = strb_mask(wstrb);

  // STATUS and IRQ_EN next values feed both their flops and irq, so irq
  // reflects the state being loaded this edge (one cycle after the cause).
  always_comb begin
    status_next = status | status_in;
    irq_en_next = irq_en_q;
    if (w_en && w_idx == IDX_STATUS) begin
      status_next = (status & ~(wdata & wmask)) | status_in;
    end
    if (w_en && w_idx == IDX_IRQ_EN) begin
      irq_en_next = merge(irq_en_q, wdata, wmask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch_q <= '0;
      ctrl_q    <= '0;
      status    <= '0;
      irq_en_q  <= '0;
      irq       <= 1'b0;
    end else begin
      if (w_en && w_idx == IDX_SCRATCH) scratch_q <= merge(scratch_q, wdata, wmask);
      if (w_en && w_idx == IDX_CTRL)    ctrl_q    <= merge(ctrl_q, wdata, wmask);
      status   <= status_next;
      irq_en_q <= irq_en_next;
      irq      <= |(status_next & irq_en_next);
    end
  end

  // Saturating event counter; a clearing write racing event_in loads 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evcnt <= '0;
    end else if (w_en && w_idx == IDX_EVCNT) begin
      evcnt <= event_in ? DATA_WIDTH'(1) : '0;
    end else if (event_in && evcnt != '1) begin
      evcnt <= evcnt + DATA_WIDTH'(1);
    end
  end

  for (genvar k = 0; k < N_USER; k++) begin : g_user
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        user_q[k] <= '0;
      end else if (w_en && w_idx == 6'(IDX_USER0 + k)) begin
        user_q[k] <= merge(user_q[k], wdata, wmask);
      end
    end
    assign user_out[32*k +: 32] = user_q[k];
  end

`ifdef AXI_CONFIG_REGFILE_TIMESTAMP_EN
  logic [DATA_WIDTH-1:0] ts_q, ts_inc;
  assign ts_inc = ts_q + DATA_WIDTH'(1);

  // Unwritten bytes keep counting, so they take the incremented value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q <= '0;
    end else if (w_en && w_idx == IDX_TS) begin
      ts_q <= merge(ts_inc, wdata, wmask);
    end else begin
      ts_q <= ts_inc;
    end
  end
  assign ts_rd = ts_q;
`else
  assign ts_rd = '0;
`endif

  // Side-effect-free read mux: safe when rd is held across stalled beats.
  always_comb begin
    rdata = '0;
    if (r_hit) begin
      case (r_idx)
        IDX_ID:      rdata = ID_VALUE;
        IDX_SCRATCH: rdata = scratch_q;
        IDX_CTRL:    rdata = ctrl_q;
        IDX_STATUS:  rdata = status;
        IDX_IRQ_EN:  rdata = irq_en_q;
        IDX_EVCNT:   rdata = evcnt;
        IDX_TS:      rdata = ts_rd;
        default: begin
          for (int k = 0; k < N_USER; k++) begin
            if (r_idx == 6'(IDX_USER0 + k)) rdata = user_q[k];
          end
        end
      endcase
    end
  end

  assign rvalid   = rd;
  assign ctrl_out = ctrl_q;

endmodule

// File: tb/tb_axi_config_regfile.sv
// Testbench for axi_config_regfile: directed stimulus pushes expected read
// responses into a queue; a monitor pops and compares on every rvalid beat.
module tb_axi_config_regfile;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rd, wr, event_in, rvalid, irq;
  logic [31:0]  raddr, waddr, wdata, rdata, status_in, ctrl_out;
  logic [3:0]   wstrb;
  logic [127:0] user_out;

  axi_config_regfile dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd        (rd),
    .raddr     (raddr),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .wr        (wr),
    .waddr     (waddr),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .status_in (status_in),
    .event_in  (event_in),
    .ctrl_out  (ctrl_out),
    .user_out  (user_out),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [31:0]  rdata;
    bit           chk_side;
    logic         irq;
    logic [31:0]  ctrl;
    logic [127:0] user;
  } exp_t;

  exp_t         sb [$];
  int           checks = 0;
  int           errors = 0;
  logic         e_irq  = 1'b0;
  logic [31:0]  e_ctrl = '0;
  logic [127:0] e_user = '0;

  // Monitor: one expectation consumed per valid read beat.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rvalid === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid: rdata=%h with no expectation queued", rdata);
      end else begin
        e = sb.pop_front();
        checks++;
        if (rdata !== e.rdata) begin
          errors++;
          $display("FAIL %s: rdata got %h expected %h", e.name, rdata, e.rdata);
        end
        if (e.chk_side) begin
          checks += 3;
          if (irq !== e.irq) begin
            errors++;
            $display("FAIL %s_irq: got %b expected %b", e.name, irq, e.irq);
          end
          if (ctrl_out !== e.ctrl) begin
            errors++;
            $display("FAIL %s_ctrl_out: got %h expected %h", e.name, ctrl_out, e.ctrl);
          end
          if (user_out !== e.user) begin
            errors++;
            $display("FAIL %s_user_out: got %h expected %h", e.name, user_out, e.user);
          end
        end
      end
    end
  end

  task automatic push(input string name, input logic [31:0] exp, input bit side);
    exp_t e;
    e.name = name; e.rdata = exp; e.chk_side = side;
    e.irq = e_irq; e.ctrl = e_ctrl; e.user = e_user;
    sb.push_back(e);
  endtask

  // Every op starts just after a posedge and ends 1 time unit after the next.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_op(input string name, input logic [31:0] a,
                       input logic [31:0] exp, input bit side);
    rd = 1'b1; raddr = a;
    push(name, exp, side);
    idle(1);
    rd = 1'b0;
  endtask

  task automatic wr_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr = 1'b1; waddr = a; wdata = d; wstrb = s;
    idle(1);
    wr = 1'b0; wstrb = '0;
  endtask

  task automatic rw_op(input string name, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp);
    rd = 1'b1; raddr = a;
    wr = 1'b1; waddr = a; wdata = d; wstrb = 4'hF;
    push(name, exp, 1'b0);
    idle(1);
    rd = 1'b0; wr = 1'b0; wstrb = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; raddr = '0; waddr = '0;
    wdata = '0; wstrb = '0; status_in = '0; event_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    rd_op("id", 32'h00, 32'h4346_4701, 1);
    rd_op("scratch_rst", 32'h04, 32'h0, 1);
    rd_op("status_rst", 32'h0C, 32'h0, 1);

    // Byte-masked CTRL write
    wr_op(32'h08, 32'hAABB_CCDD, 4'b0101);
    e_ctrl = 32'h00BB_00DD;
    rd_op("ctrl_strb", 32'h08, 32'h00BB_00DD, 1);
    rd_op("ctrl_addr_lsb", 32'h0B, 32'h00BB_00DD, 0);

    // SCRATCH, and read-during-write returns the old value
    wr_op(32'h04, 32'h1234_5678, 4'hF);
    rw_op("rw_same_reg", 32'h04, 32'hCAFE_F00D, 32'h1234_5678);
    rd_op("scratch_new", 32'h04, 32'hCAFE_F00D, 0);

    // STATUS / IRQ
    wr_op(32'h10, 32'h10, 4'hF);
    rd_op("irq_en", 32'h10, 32'h10, 1);
    status_in = 32'h11; idle(1); status_in = '0;
    e_irq = 1'b1;
    rd_op("status_set", 32'h0C, 32'h11, 1);
    wr_op(32'h0C, 32'h10, 4'hF);
    e_irq = 1'b0;
    rd_op("status_w1c", 32'h0C, 32'h01, 1);
    status_in = 32'h01; wr_op(32'h0C, 32'h01, 4'hF); status_in = '0;
    rd_op("status_set_wins", 32'h0C, 32'h01, 0);
    wr_op(32'h0C, 32'hFFFF_FFFF, 4'h0);
    rd_op("status_strb0", 32'h0C, 32'h01, 0);
    wr_op(32'h10, 32'h01, 4'hF);
    e_irq = 1'b1;
    rd_op("irq_from_en", 32'h10, 32'h01, 1);
    wr_op(32'h10, 32'h00, 4'hF);
    e_irq = 1'b0;
    rd_op("irq_off", 32'h0C, 32'h01, 1);

    // EVCNT
    event_in = 1'b1; idle(5); event_in = 1'b0;
    rd_op("evcnt5", 32'h14, 32'd5, 0);
    wr_op(32'h14, 32'h0, 4'h0);
    rd_op("evcnt_strb0", 32'h14, 32'd5, 0);
    event_in = 1'b1; wr_op(32'h14, 32'h0, 4'hF); event_in = 1'b0;
    rd_op("evcnt_clr_evt", 32'h14, 32'd1, 0);
    force dut.evcnt = 32'hFFFF_FFFD;
    #1 release dut.evcnt;
    event_in = 1'b1; idle(4); event_in = 1'b0;
    rd_op("evcnt_sat", 32'h14, 32'hFFFF_FFFF, 0);

    // Decode
    rd_op("unmapped", 32'h40, 32'h0, 0);
    rd_op("out_of_bank", 32'h104, 32'h0, 0);
    wr_op(32'h104, 32'hDEAD_BEEF, 4'hF);
    rd_op("alias_ignored", 32'h04, 32'hCAFE_F00D, 0);

    // USER
    wr_op(32'h20, 32'h1111_1111, 4'hF);
    wr_op(32'h2C, 32'h4444_4444, 4'b0011);
    e_user[31:0]   = 32'h1111_1111;
    e_user[127:96] = 32'h0000_4444;
    rd_op("user3", 32'h2C, 32'h0000_4444, 1);
    wr_op(32'h30, 32'hFFFF_FFFF, 4'hF);
    rd_op("user_oob", 32'h30, 32'h0, 1);

    // Held read is idempotent
    rd = 1'b1; raddr = 32'h0C;
    for (int i = 0; i < 10; i++) push("status_hold", 32'h01, 1'b0);
    idle(10);
    rd = 1'b0;

`ifdef AXI_CONFIG_REGFILE_TIMESTAMP_EN
    wr_op(32'h18, 32'h0000_1000, 4'hF);
    rd_op("ts_load", 32'h18, 32'h0000_1000, 0);
    idle(2);
    rd_op("ts_plus3", 32'h18, 32'h0000_1003, 0);
    wr_op(32'h18, 32'hAB00_0000, 4'b1000);
    rd_op("ts_partial", 32'h18, 32'hAB00_1005, 0);
    wr_op(32'h18, 32'hFFFF_FFFF, 4'hF);
    rd_op("ts_max", 32'h18, 32'hFFFF_FFFF, 0);
    rd_op("ts_wrap", 32'h18, 32'h0, 0);
`else
    wr_op(32'h18, 32'hFFFF_FFFF, 4'hF);
    rd_op("ts_absent", 32'h18, 32'h0, 0);
`endif

    // Asynchronous reset between clock edges
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    e_ctrl = '0; e_user = '0; e_irq = 1'b0;
    idle(1);
    rd_op("async_rst_scratch", 32'h04, 32'h0, 1);
    rd_op("async_rst_status", 32'h0C, 32'h0, 1);

    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
